// File: rtl/numbers_flat_pkg.sv
// numbers_flat_pkg: field layout, FSM states and golden constants of the numbers_constant flat frame
package numbers_flat_pkg;
    localparam int FRAME_W = 80;
    localparam int DEC_W   = 32;
    localparam int DEC_LSB = 48;
    localparam int BIN_W   = 16;
    localparam int BIN_LSB = 32;
    localparam int OCT_W   = 12;
    localparam int OCT_LSB = 20;
    localparam int HEX_W   = 16;
    localparam int HEX_LSB = 4;
    localparam int UNS_W   = 4;
    localparam int UNS_LSB = 0;
    typedef enum logic {COLLECT, HOLD} state_t;
    localparam logic [DEC_W-1:0] GOLD_DEC     = 32'd100;
    localparam logic [BIN_W-1:0] GOLD_BIN     = 16'hAAAA;
    localparam logic [OCT_W-1:0] GOLD_OCT     = 12'o7654;
    localparam logic [HEX_W-1:0] GOLD_HEX     = 16'hBEEF;
    localparam logic [UNS_W-1:0] GOLD_UNSIZED = 4'h5;
endpackage

// File: rtl/numbers_flat_field_slicer.sv
// numbers_flat_field_slicer: splits a flat frame into its constant fields; golden compare with NUMBERS_GOLDEN_CHECK_EN
module numbers_flat_field_slicer
    import numbers_flat_pkg::*;
(
    input  logic [FRAME_W-1:0] flat,
    output logic [DEC_W-1:0]   dec,
    output logic [BIN_W-1:0]   bin,
    output logic [OCT_W-1:0]   oct,
    output logic [HEX_W-1:0]   hex,
    output logic [UNS_W-1:0]   unsized
`ifdef NUMBERS_GOLDEN_CHECK_EN
    ,
    output logic               mismatch
`endif
);
    assign dec     = flat[DEC_LSB +: DEC_W];
    assign bin     = flat[BIN_LSB +: BIN_W];
    assign oct     = flat[OCT_LSB +: OCT_W];
    assign hex     = flat[HEX_LSB +: HEX_W];
    assign unsized = flat[UNS_LSB +: UNS_W];
`ifdef NUMBERS_GOLDEN_CHECK_EN
    assign mismatch = (dec != GOLD_DEC) || (bin != GOLD_BIN) || (oct != GOLD_OCT) ||
                      (hex != GOLD_HEX) || (unsized != GOLD_UNSIZED);
`endif
endmodule

// File: rtl/numbers_flat_deserializer.sv
// numbers_flat_deserializer: reassembles MSB-first beats into a flat frame and presents its fields; NUMBERS_GOLDEN_CHECK_EN adds mismatch
module numbers_flat_deserializer
    import numbers_flat_pkg::*;
#(
    parameter int FLAT_W  = 80,
    parameter int CHUNK_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [CHUNK_W-1:0] s_data,
    input  logic               s_last,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [DEC_W-1:0]   const_dec,
    output logic [BIN_W-1:0]   const_bin,
    output logic [OCT_W-1:0]   const_oct,
    output logic [HEX_W-1:0]   const_hex,
    output logic [UNS_W-1:0]   const_unsized,
    output logic               frame_err
`ifdef NUMBERS_GOLDEN_CHECK_EN
    ,
    output logic               mismatch
`endif
);
    localparam int NBEATS = FLAT_W / CHUNK_W;
    localparam int CNT_W = NBEATS > 1 ? $clog2(NBEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

    if (FLAT_W % CHUNK_W != 0) begin : g_bad_width
        $error("FLAT_W must be an exact multiple of CHUNK_W");
    end

    state_t state, next_state;
    logic [CNT_W-1:0] beat_cnt;
    logic [FLAT_W-1:0] shift_q, frame_next;
    logic accept, final_beat;
    logic [DEC_W-1:0] dec_n;
    logic [BIN_W-1:0] bin_n;
    logic [OCT_W-1:0] oct_n;
    logic [HEX_W-1:0] hex_n;
    logic [UNS_W-1:0] uns_n;
`ifdef NUMBERS_GOLDEN_CHECK_EN
    logic mis_n;
`endif

    assign accept     = s_valid && s_ready;
    assign final_beat = beat_cnt == LAST_BEAT;
    assign frame_next = (shift_q << CHUNK_W) | FLAT_W'(s_data);

    numbers_flat_field_slicer u_slicer (
        .flat     (frame_next),
        .dec      (dec_n),
        .bin      (bin_n),
        .oct      (oct_n),
        .hex      (hex_n),
        .unsized  (uns_n)
`ifdef NUMBERS_GOLDEN_CHECK_EN
        ,
        .mismatch (mis_n)
`endif
    );

    // next state and handshake outputs; s_ready and m_valid depend on state only
    always_comb begin
        next_state = state == COLLECT ? ((accept && final_beat) ? HOLD : COLLECT)
                                      : (m_ready ? COLLECT : HOLD);
        s_ready    = state == COLLECT;
        m_valid    = state == HOLD;
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= COLLECT;
        else     state <= next_state;
    end

    // beat collection and framing check: early s_last drops the partial frame, missing s_last only flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt  <= '0;
            shift_q   <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (accept) begin
                if (final_beat) begin
                    beat_cnt  <= '0;
                    shift_q   <= frame_next;
                    frame_err <= !s_last;
                end else if (s_last) begin
                    beat_cnt  <= '0;
                    shift_q   <= '0;
                    frame_err <= 1'b1;
                end else begin
                    beat_cnt  <= beat_cnt + 1'b1;
                    shift_q   <= frame_next;
                end
            end
        end
    end

    // field registers load from the completed frame on the final-beat edge and hold through HOLD
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            const_dec     <= '0;
            const_bin     <= '0;
            const_oct     <= '0;
            const_hex     <= '0;
            const_unsized <= '0;
`ifdef NUMBERS_GOLDEN_CHECK_EN
            mismatch      <= 1'b0;
`endif
        end else if (accept && final_beat) begin
            const_dec     <= dec_n;
            const_bin     <= bin_n;
            const_oct     <= oct_n;
            const_hex     <= hex_n;
            const_unsized <= uns_n;
`ifdef NUMBERS_GOLDEN_CHECK_EN
            mismatch      <= mis_n;
`endif
        end
    end
endmodule

// File: tb/tb_numbers_flat_deserializer.sv
// tb_numbers_flat_deserializer: directed frames checked against a beat-queue model plus literal field expectations
module tb_numbers_flat_deserializer;
    localparam int NB = 5;

    logic        clk = 0;
    logic        rst = 1;
    logic        s_valid = 0;
    logic        s_ready;
    logic [15:0] s_data = '0;
    logic        s_last = 0;
    logic        m_valid;
    logic        m_ready = 1;
    logic [31:0] const_dec;
    logic [15:0] const_bin;
    logic [11:0] const_oct;
    logic [15:0] const_hex;
    logic [3:0]  const_unsized;
    logic        frame_err;
`ifdef NUMBERS_GOLDEN_CHECK_EN
    logic        mismatch;
`endif

    int tests = 0;
    int fails = 0;

    numbers_flat_deserializer dut (
        .clk           (clk),
        .rst           (rst),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .s_last        (s_last),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .const_dec     (const_dec),
        .const_bin     (const_bin),
        .const_oct     (const_oct),
        .const_hex     (const_hex),
        .const_unsized (const_unsized),
        .frame_err     (frame_err)
`ifdef NUMBERS_GOLDEN_CHECK_EN
        ,
        .mismatch      (mismatch)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    logic [15:0] q[$];
    logic [79:0] exp_frame = '0;
    bit exp_hold = 0;
    bit exp_err = 0;
    bit was_hold;

    // frame model: beats queue up; NB of them make a frame, an early s_last throws the queue away
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            exp_hold = 0;
            exp_err = 0;
            exp_frame = '0;
        end else begin
            was_hold = exp_hold;
            exp_err = 0;
            if (was_hold && m_ready) exp_hold = 0;
            if (!was_hold && s_valid) begin
                q.push_back(s_data);
                if (q.size() == NB) begin
                    exp_frame = '0;
                    foreach (q[i]) exp_frame = (exp_frame << 16) | 80'(q[i]);
                    exp_hold = 1;
                    exp_err = !s_last;
                    q.delete();
                end else if (s_last) begin
                    exp_err = 1;
                    q.delete();
                end
            end
        end
    end

    // every cycle out of reset: handshake flags and, while a frame is held, its fields
    always @(negedge clk) begin
        if (!rst) begin
            chk("s_ready", 64'(s_ready), 64'(!exp_hold));
            chk("m_valid", 64'(m_valid), 64'(exp_hold));
            chk("frame_err", 64'(frame_err), 64'(exp_err));
            if (exp_hold) begin
                chk("dec", 64'(const_dec), 64'(exp_frame[79:48]));
                chk("bin", 64'(const_bin), 64'(exp_frame[47:32]));
                chk("oct", 64'(const_oct), 64'(exp_frame[31:20]));
                chk("hex", 64'(const_hex), 64'(exp_frame[19:4]));
                chk("unsized", 64'(const_unsized), 64'(exp_frame[3:0]));
`ifdef NUMBERS_GOLDEN_CHECK_EN
                chk("mismatch", 64'(mismatch), 64'(exp_frame != 80'h0000_0064_AAAA_FACB_EEF5));
`endif
            end
        end
    end

    task automatic beat(input logic [15:0] d, input bit l);
        int n = 0;
        s_valid = 1;
        s_data = d;
        s_last = l;
        while (!s_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n == 50) chk("beat_timeout", 64'(n), 64'(0));
        @(posedge clk);
        #1;
        s_valid = 0;
        s_last = 0;
    endtask

    task automatic frame(input logic [15:0] b4, input bit with_last);
        beat(16'h0000, 0);
        beat(16'h0064, 0);
        beat(16'hAAAA, 0);
        beat(16'hFACB, 0);
        beat(b4, with_last);
    endtask

    task automatic check_zero(input string name);
        chk({name, "_m_valid"}, 64'(m_valid), 64'(0));
        chk({name, "_err"}, 64'(frame_err), 64'(0));
        chk({name, "_fields"}, {const_dec, const_bin, const_hex}, 64'(0));
        chk({name, "_oct_uns"}, 64'({const_oct, const_unsized}), 64'(0));
`ifdef NUMBERS_GOLDEN_CHECK_EN
        chk({name, "_mismatch"}, 64'(mismatch), 64'(0));
`endif
    endtask

    initial begin
        #1;
        check_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        chk("ready_after_reset", 64'(s_ready), 64'(1));

        frame(16'hEEF5, 1);
        chk("golden_valid", 64'(m_valid), 64'(1));
        chk("golden_dec", 64'(const_dec), 64'd100);
        chk("golden_bin", 64'(const_bin), 64'hAAAA);
        chk("golden_oct", 64'(const_oct), 64'o7654);
        chk("golden_hex", 64'(const_hex), 64'hBEEF);
        chk("golden_uns", 64'(const_unsized), 64'h5);
        chk("golden_err", 64'(frame_err), 64'(0));
`ifdef NUMBERS_GOLDEN_CHECK_EN
        chk("golden_mismatch", 64'(mismatch), 64'(0));
`endif
        @(posedge clk);
        #1;
        chk("golden_released", 64'(m_valid), 64'(0));

        m_ready = 0;
        frame(16'hEEF5, 1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 64'(m_valid), 64'(1));
            chk("bp_ready", 64'(s_ready), 64'(0));
            chk("bp_hex", 64'(const_hex), 64'hBEEF);
            @(posedge clk);
            #1;
        end
        m_ready = 1;
        @(posedge clk);
        #1;
        chk("bp_done_valid", 64'(m_valid), 64'(0));
        chk("bp_done_ready", 64'(s_ready), 64'(1));

        beat(16'h1111, 0);
        beat(16'h2222, 0);
        beat(16'h3333, 1);
        chk("early_err", 64'(frame_err), 64'(1));
        chk("early_no_valid", 64'(m_valid), 64'(0));
        @(posedge clk);
        #1;
        chk("early_err_pulse", 64'(frame_err), 64'(0));
        frame(16'hEEF5, 1);
        chk("after_early_dec", 64'(const_dec), 64'd100);
        chk("after_early_uns", 64'(const_unsized), 64'h5);
        @(posedge clk);
        #1;

        frame(16'hEEF5, 0);
        chk("nolast_err", 64'(frame_err), 64'(1));
        chk("nolast_valid", 64'(m_valid), 64'(1));
        chk("nolast_hex", 64'(const_hex), 64'hBEEF);
        @(posedge clk);
        #1;

        beat(16'h0000, 0);
        beat(16'h0064, 0);
        rst = 1;
        #1;
        check_zero("midreset");
        @(posedge clk);
        #1;
        rst = 0;
        frame(16'hEEF5, 1);
        chk("post_reset_dec", 64'(const_dec), 64'd100);
        chk("post_reset_oct", 64'(const_oct), 64'o7654);
        @(posedge clk);
        #1;

        frame(16'hEEF4, 1);
        chk("bad_uns", 64'(const_unsized), 64'h4);
`ifdef NUMBERS_GOLDEN_CHECK_EN
        chk("bad_mismatch", 64'(mismatch), 64'(1));
`endif
        @(posedge clk);
        #1;
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
